// File: rtl/adc_sum_sq_acc_if.sv
// ADC sample stream in, sum-of-squares results out, for one power-monitor input.
interface adc_sum_sq_acc_if #(
    parameter int unsigned N_PAR  = 4,
    parameter int unsigned DATA_W = 8
);
    logic [N_PAR*DATA_W-1:0] adc_data;
    logic                    adc_valid;
    logic                    sync;
    logic [15:0]             acc_len;
    logic [31:0]             sum_sq;
    logic                    sum_valid;
    logic                    sat;
    logic [31:0]             int_count;

    modport master (
        output adc_data, adc_valid, sync, acc_len,
        input  sum_sq, sum_valid, sat, int_count
    );

    modport slave (
        input  adc_data, adc_valid, sync, acc_len,
        output sum_sq, sum_valid, sat, int_count
    );
endinterface

// File: rtl/adc_sum_sq_acc.sv
// Squares parallel ADC samples and integrates them over acc_len+1 valid cycles;
// the saturated 32-bit total is held for the software-readable power register.
module adc_sum_sq_acc #(
    parameter int unsigned N_PAR  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 48
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    adc_sum_sq_acc_if.slave  bus
);
    localparam int unsigned BUS_W  = N_PAR * DATA_W;
    localparam int unsigned SQ_W   = 2 * DATA_W - 1;
    localparam int unsigned TREE_W = SQ_W + $clog2(N_PAR);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned OUT_W  = 32;

    typedef enum logic [0:0] {ARM, RUN} state_t;

    state_t              state_q, state_d;
    logic [BUS_W-1:0]    data0_q;
    logic                v0_q, s0_q, v1_q, s1_q, v2_q, s2_q;
    logic [SQ_W-1:0]     sq_q [N_PAR];
    logic [SQ_W-1:0]     sq_d [N_PAR];
    logic [TREE_W-1:0]   tree_q, tree_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LEN_W-1:0]    n_q, n_d, len_q, len_d;
    logic [OUT_W-1:0]    sum_sq_q, sum_sq_d, cnt_q, cnt_d;
    logic                sat_q, sat_d, sum_valid_q, sum_valid_d;

    // Per-lane signed square; the magnitude always fits in 2*DATA_W-1 bits.
    always_comb begin
        logic signed [DATA_W-1:0]   lane;
        logic signed [2*DATA_W-1:0] prod;
        for (int i = 0; i < N_PAR; i++) begin
            lane    = $signed(data0_q[i*DATA_W +: DATA_W]);
            prod    = (2*DATA_W)'(lane) * (2*DATA_W)'(lane);
            sq_d[i] = SQ_W'(prod);
        end
    end

    always_comb begin
        tree_d = '0;
        for (int i = 0; i < N_PAR; i++) begin
            tree_d = tree_d + TREE_W'(sq_q[i]);
        end
    end

    // Integration control: a sync tag restarts from empty in either state,
    // and its own valid sample is sample 1 of the new integration.
    always_comb begin
        logic [ACC_W-1:0] acc_base, acc_new;
        logic [ACC_W:0]   sum_ext;
        logic [LEN_W-1:0] n_base, len_base;
        logic             active, clip;

        state_d     = state_q;
        acc_d       = acc_q;
        n_d         = n_q;
        len_d       = len_q;
        sum_sq_d    = sum_sq_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        sum_valid_d = 1'b0;

        acc_base = acc_q;
        n_base   = n_q;
        len_base = len_q;
        active   = (state_q == RUN);

        if (s2_q) begin
            state_d  = RUN;
            active   = 1'b1;
            acc_base = '0;
            n_base   = '0;
            len_base = bus.acc_len;
        end

        sum_ext = {1'b0, acc_base} + (ACC_W+1)'(tree_q);
        acc_new = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        clip    = |acc_new[ACC_W-1:OUT_W];

        if (active) begin
            acc_d = acc_base;
            n_d   = n_base;
            len_d = len_base;
            if (v2_q) begin
                if (n_base == len_base) begin
                    sum_sq_d    = clip ? '1 : acc_new[OUT_W-1:0];
                    sat_d       = clip;
                    sum_valid_d = 1'b1;
                    cnt_d       = cnt_q + OUT_W'(1);
                    acc_d       = '0;
                    n_d         = '0;
                    len_d       = bus.acc_len;
                end else begin
                    acc_d = acc_new;
                    n_d   = n_base + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= ARM;
            data0_q     <= '0;
            v0_q        <= 1'b0;
            s0_q        <= 1'b0;
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s2_q        <= 1'b0;
            for (int i = 0; i < N_PAR; i++) sq_q[i] <= '0;
            tree_q      <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            len_q       <= '0;
            sum_sq_q    <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data0_q     <= bus.adc_data;
            v0_q        <= bus.adc_valid;
            s0_q        <= bus.sync;
            sq_q        <= sq_d;
            v1_q        <= v0_q;
            s1_q        <= s0_q;
            tree_q      <= tree_d;
            v2_q        <= v1_q;
            s2_q        <= s1_q;
            acc_q       <= acc_d;
            n_q         <= n_d;
            len_q       <= len_d;
            sum_sq_q    <= sum_sq_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.sum_sq    = sum_sq_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.sat       = sat_q;
    assign bus.int_count = cnt_q;

endmodule

// File: tb/tb_adc_sum_sq_acc.sv
// Randomized and directed bench for adc_sum_sq_acc against a delayed-stream reference model.
module tb_adc_sum_sq_acc;
    localparam longint unsigned ACC_MAX = 64'h0000_FFFF_FFFF_FFFF;

    logic user_clk = 1'b0;
    logic user_rst_n = 1'b0;
    always #5 user_clk = ~user_clk;

    adc_sum_sq_acc_if #(.N_PAR(4), .DATA_W(8)) bus ();

    adc_sum_sq_acc #(.N_PAR(4), .DATA_W(8), .ACC_W(48)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .bus        (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        v;
        logic        s;
    } cap_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: samples emerge three edges after capture.
    cap_t             pipe_m[$];
    bit               armed;
    longint unsigned  acc_m;
    int unsigned      taken_m, len_m;
    logic [31:0]      exp_sum, exp_cnt;
    logic             exp_sat, exp_valid;

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    function automatic longint unsigned sq_sum(input logic [31:0] d);
        longint unsigned t = 0;
        for (int i = 0; i < 4; i++) begin
            int x;
            x = int'($signed(d[i*8 +: 8]));
            t += 64'(x * x);
        end
        return t;
    endfunction

    task automatic model_reset();
        pipe_m.delete();
        armed = 0; acc_m = 0; taken_m = 0; len_m = 0;
        exp_sum = '0; exp_cnt = '0; exp_sat = 1'b0; exp_valid = 1'b0;
    endtask

    task automatic model_step(input cap_t o, input logic [15:0] live_len);
        if (o.s) begin
            armed = 1; acc_m = 0; taken_m = 0; len_m = live_len;
        end
        if (armed && o.v) begin
            acc_m = acc_m + sq_sum(o.d);
            if (acc_m > ACC_MAX) acc_m = ACC_MAX;
            taken_m++;
            if (taken_m == len_m + 1) begin
                exp_valid = 1'b1;
                exp_sat   = (acc_m > 64'h0000_0000_FFFF_FFFF);
                exp_sum   = exp_sat ? 32'hFFFF_FFFF : 32'(acc_m);
                exp_cnt   = exp_cnt + 32'd1;
                acc_m = 0; taken_m = 0; len_m = live_len;
            end
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic v, input logic s);
        bus.adc_data  = d;
        bus.adc_valid = v;
        bus.sync      = s;
    endtask

    task automatic tick();
        cap_t c;
        @(posedge user_clk);
        exp_valid = 1'b0;
        if (!user_rst_n) begin
            model_reset();
        end else begin
            c.d = bus.adc_data; c.v = bus.adc_valid; c.s = bus.sync;
            pipe_m.push_back(c);
            if (pipe_m.size() > 3) model_step(pipe_m.pop_front(), bus.acc_len);
        end
        @(negedge user_clk);
    endtask

    task automatic test_reset();
        user_rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive($urandom, 1'($urandom), 1'($urandom));
            bus.acc_len = 16'($urandom);
            tick();
            n_checks += 4;
            if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset sum_valid got %0b want 0", bus.sum_valid); end
            if (bus.sum_sq !== 32'd0) begin n_fail++; $display("FAIL reset sum_sq got %0h want 0", bus.sum_sq); end
            if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL reset sat got %0b want 0", bus.sat); end
            if (bus.int_count !== 32'd0) begin n_fail++; $display("FAIL reset int_count got %0h want 0", bus.int_count); end
        end
        drive($urandom, 1'b1, 1'b0);
        user_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL arm sum_valid got %0b want %0b", bus.sum_valid, exp_valid); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL arm sum_sq got %0h want %0h", bus.sum_sq, exp_sum); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL arm sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL arm int_count got %0h want %0h", bus.int_count, exp_cnt); end
            drive($urandom, 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_ones();
        int first = -1;
        bus.acc_len = 16'd3;
        drive(rep(8'h01), 1'b1, 1'b1);
        for (int k = 0; k < 26; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL ones sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL ones sum_sq got %0h want %0h k=%0d", bus.sum_sq, exp_sum, k); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL ones sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL ones int_count got %0h want %0h", bus.int_count, exp_cnt); end
            if (bus.sum_valid === 1'b1 && first < 0) first = k;
            drive(rep(8'h01), 1'b1, 1'b0);
        end
        n_checks++;
        if (first != 6) begin n_fail++; $display("FAIL ones_latency first pulse at +%0d want +6", first); end
    endtask

    task automatic test_neg_full();
        bus.acc_len = 16'd0;
        drive(rep(8'h80), 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL neg sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL neg sum_sq got %0h want %0h", bus.sum_sq, exp_sum); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL neg sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL neg int_count got %0h want %0h", bus.int_count, exp_cnt); end
            drive(rep(8'h80), 1'b1, 1'b0);
        end
        n_checks++;
        if (bus.sum_sq !== 32'd65536) begin n_fail++; $display("FAIL neg_value sum_sq got %0h want 10000", bus.sum_sq); end
    endtask

    task automatic test_saturate();
        bit saw_sat = 0;
        bus.acc_len = 16'hFFFF;
        drive(rep(8'h80), 1'b1, 1'b1);
        for (int k = 0; k < 65540; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL sat_run sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL sat_run sum_sq got %0h want %0h", bus.sum_sq, exp_sum); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL sat_run sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL sat_run int_count got %0h want %0h", bus.int_count, exp_cnt); end
            if (bus.sum_valid === 1'b1 && bus.sat === 1'b1 && bus.sum_sq === 32'hFFFF_FFFF) saw_sat = 1;
            drive(rep(8'h80), 1'b1, 1'b0);
        end
        n_checks++;
        if (!saw_sat) begin n_fail++; $display("FAIL sat_clip saw_clip got 0 want 1"); end
        bus.acc_len = 16'd0;
        drive(32'd0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL unsat sum_valid got %0b want %0b", bus.sum_valid, exp_valid); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL unsat sum_sq got %0h want %0h", bus.sum_sq, exp_sum); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL unsat sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL unsat int_count got %0h want %0h", bus.int_count, exp_cnt); end
            drive(32'd0, 1'b1, 1'b0);
        end
        n_checks += 2;
        if (bus.sum_sq !== 32'd0) begin n_fail++; $display("FAIL unsat_value sum_sq got %0h want 0", bus.sum_sq); end
        if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL unsat_flag sat got %0b want 0", bus.sat); end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        bus.acc_len = 16'd7;
        drive(rep(8'h02), 1'b1, 1'b1);
        for (int k = 0; k < 44; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL gaps sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL gaps sum_sq got %0h want %0h k=%0d", bus.sum_sq, exp_sum, k); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL gaps sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL gaps int_count got %0h want %0h", bus.int_count, exp_cnt); end
            if (bus.sum_valid === 1'b1) pulses++;
            if (k == 5) bus.acc_len = 16'd3;
            drive(rep(8'h02), 1'((k + 1) % 2 == 0), 1'b0);
        end
        n_checks++;
        if (pulses < 2) begin n_fail++; $display("FAIL gaps_pulses got %0d want >=2", pulses); end
    endtask

    task automatic test_sync_restart();
        bus.acc_len = 16'd7;
        drive($urandom, 1'b1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL restart sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL restart sum_sq got %0h want %0h", bus.sum_sq, exp_sum); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL restart sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL restart int_count got %0h want %0h", bus.int_count, exp_cnt); end
            drive($urandom, 1'b1, 1'(k == 3));
        end
        bus.acc_len = 16'd3;
        drive($urandom, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL coincide sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL coincide sum_sq got %0h want %0h", bus.sum_sq, exp_sum); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL coincide sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL coincide int_count got %0h want %0h", bus.int_count, exp_cnt); end
            drive($urandom, 1'b1, 1'(k == 2));
        end
    endtask

    task automatic test_reset_mid();
        bus.acc_len = 16'd5;
        drive($urandom, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            drive($urandom, 1'b1, 1'b0);
        end
        user_rst_n = 1'b0;
        #1;
        model_reset();
        n_checks += 4;
        if (bus.sum_valid !== 1'b0) begin n_fail++; $display("FAIL midrst sum_valid got %0b want 0", bus.sum_valid); end
        if (bus.sum_sq !== 32'd0) begin n_fail++; $display("FAIL midrst sum_sq got %0h want 0", bus.sum_sq); end
        if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL midrst sat got %0b want 0", bus.sat); end
        if (bus.int_count !== 32'd0) begin n_fail++; $display("FAIL midrst int_count got %0h want 0", bus.int_count); end
        tick();
        tick();
        user_rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            drive($urandom, 1'b1, 1'(k == 15));
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL rearm sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL rearm sum_sq got %0h want %0h", bus.sum_sq, exp_sum); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL rearm sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL rearm int_count got %0h want %0h", bus.int_count, exp_cnt); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) bus.acc_len = 16'($urandom_range(0, 5));
            drive($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
            tick();
            n_checks += 4;
            if (bus.sum_valid !== exp_valid) begin n_fail++; $display("FAIL rand sum_valid got %0b want %0b k=%0d", bus.sum_valid, exp_valid, k); end
            if (bus.sum_sq !== exp_sum) begin n_fail++; $display("FAIL rand sum_sq got %0h want %0h k=%0d", bus.sum_sq, exp_sum, k); end
            if (bus.sat !== exp_sat) begin n_fail++; $display("FAIL rand sat got %0b want %0b", bus.sat, exp_sat); end
            if (bus.int_count !== exp_cnt) begin n_fail++; $display("FAIL rand int_count got %0h want %0h", bus.int_count, exp_cnt); end
        end
    endtask

    initial begin
        model_reset();
        drive(32'd0, 1'b0, 1'b0);
        bus.acc_len = 16'd0;
        @(negedge user_clk);
        test_reset();
        test_ones();
        test_neg_full();
        test_saturate();
        test_gaps();
        test_sync_restart();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
